// File: rtl/video_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_ctrl_pkg
// Brief    : Shared types and constants for the video core control sequencer
// Revision : 1.0
// ============================================================================
package video_ctrl_pkg;

    localparam int AVS_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : 2-FF synchroniser followed by a per-bit consecutive-cycle debouncer
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int               WIDTH           = 1,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int               c_cnt_w  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_LEVEL;
            r_sync <= RESET_LEVEL;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
        end
    end

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_deb;

            // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_deb <= RESET_LEVEL[b];
                end else if (r_sync[b] == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_cnt <= '0;
                    r_deb <= r_sync[b];
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end

            assign deb[b] = r_deb;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_bypass_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : video_bypass_write_sequencer
// Brief    : Debounced trigger/switch capture driving one Avalon-MM write per core
// Revision : 1.0
// ============================================================================
module video_bypass_write_sequencer
    import video_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int ADDR_W          = 1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int AUTO_UPDATE     = 0,
    parameter int INIT_ON_RESET   = 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  trigger_n,
    input  logic [NUM_CH-1:0]     sw_in,
    output logic [NUM_CH-1:0]     avs_write,
    output logic [ADDR_W-1:0]     avs_address,
    output logic [AVS_DATA_W-1:0] avs_writedata,
    input  logic [NUM_CH-1:0]     avs_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_CH-1:0]     err
);

    localparam int                  c_idx_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                  c_wait_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(NUM_CH - 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT_CYCLES);
    localparam logic [NUM_CH-1:0]   c_strobe0   = NUM_CH'(1);

    logic                w_trig_deb;
    logic [NUM_CH-1:0]   w_sw_deb;
    logic [c_idx_w-1:0]  w_idx_next;
    logic                w_start;

    logic                r_trig_prev;
    logic                r_press;
    seq_state_t          r_state;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_wait_w-1:0] r_wait;
    logic                r_pending;
    logic                r_init;
    logic [NUM_CH-1:0]   r_snapshot;

    key_debounce #(
        .WIDTH           (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_trig_deb (
        .clk (sys_clk),
        .rst (sys_rst),
        .raw (trigger_n),
        .deb (w_trig_deb)
    );

    key_debounce #(
        .WIDTH           (NUM_CH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     ('0)
    ) u_sw_deb (
        .clk (sys_clk),
        .rst (sys_rst),
        .raw (sw_in),
        .deb (w_sw_deb)
    );

    assign avs_address = '0;
    assign w_idx_next  = r_idx + c_idx_w'(1);
    assign w_start     = r_press | r_pending | r_init |
                         ((AUTO_UPDATE != 0) && (w_sw_deb != r_snapshot));

    // Press is the falling edge of the debounced (active-low) trigger only.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_trig_prev <= 1'b1;
            r_press     <= 1'b0;
        end else begin
            r_trig_prev <= w_trig_deb;
            r_press     <= r_trig_prev & ~w_trig_deb;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_wait        <= '0;
            r_pending     <= 1'b0;
            r_init        <= (INIT_ON_RESET != 0);
            r_snapshot    <= '0;
            avs_write     <= '0;
            avs_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= '0;
        end else begin
            done <= 1'b0;
            if (r_press && (r_state != IDLE)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_init <= 1'b0;
                    if (w_start) begin
                        busy    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_snapshot    <= w_sw_deb;
                    r_idx         <= '0;
                    r_wait        <= '0;
                    // A press landing on this very cycle still earns a rerun.
                    r_pending     <= r_press;
                    avs_write     <= c_strobe0;
                    avs_writedata <= {{(AVS_DATA_W-1){1'b0}}, w_sw_deb[0]};
                    r_state       <= WRITE;
                end
                WRITE: begin
                    if (!avs_waitrequest[r_idx]) begin
                        avs_write <= '0;
                        r_state   <= NEXT;
                    end else if (r_wait == c_wait_last) begin
                        avs_write    <= '0;
                        err[r_idx]   <= 1'b1;
                        r_state      <= NEXT;
                    end else begin
                        r_wait <= r_wait + c_wait_w'(1);
                    end
                end
                NEXT: begin
                    if (r_idx == c_last_idx) begin
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx         <= w_idx_next;
                        r_wait        <= '0;
                        avs_write     <= c_strobe0 << w_idx_next;
                        avs_writedata <= {{(AVS_DATA_W-1){1'b0}}, r_snapshot[w_idx_next]};
                        r_state       <= WRITE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
